mux_sel_sequencer: RTL and testbench

- Upstream control stage for the 4:1 board multiplexer: generates its 2-bit select from a debounced pushbutton or an auto-scan timer.
- SEL drives the mux select inputs directly; LEDR shows a one-hot view of the current selection.
- Fully synchronous to CLOCK_50 with an asynchronous active-low reset.

---
 rtl/mux_sel_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// Select sequencer for the 4:1 board mux: debounced step key plus auto-scan timer.
// Define AUTOREPEAT_EN to add hold-to-repeat on the step key.
module mux_sel_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned SCAN_DIV        = 25000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 10000000
) (
   input  logic       CLOCK_50,
   input  logic [0:1] KEY,
   input  logic [0:1] SW,
   output logic [0:1] SEL,
   output logic [0:3] LEDR,
   output logic       STEP
);
   localparam int unsigned MAX_A = (DEBOUNCE_CYCLES > SCAN_DIV) ? DEBOUNCE_CYCLES : SCAN_DIV;
   localparam int unsigned MAX_B = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } db_state_e;

   logic          clk;
   logic          rst_n;
   db_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]    key_sync_q, key_sync_d;
   logic [1:0]    en_sync_q, en_sync_d;
   logic [1:0]    dir_sync_q, dir_sync_d;
   logic [1:0]    sel_q, sel_d;
   logic [0:3]    led_q, led_d;
   logic          step_q, step_d;
   logic          key_s, en_s, dir_s;
   logic          press_evt_c, tick_c, repeat_evt_c, adv_c;

   assign clk   = CLOCK_50;
   assign rst_n = KEY[0];

   // Two-flop synchronizers; the key is inverted so pressed reads as 1
   always_comb begin
      key_sync_d = {key_sync_q[0], ~KEY[1]};
      en_sync_d  = {en_sync_q[0], SW[0]};
      dir_sync_d = {dir_sync_q[0], SW[1]};
      key_s      = key_sync_q[1];
      en_s       = en_sync_q[1];
      dir_s      = dir_sync_q[1];
   end

   // Debounce FSM: a level is accepted once it has held for DEBOUNCE_CYCLES
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      press_evt_c = 1'b0;
      case (state_q)
         RELEASED: begin
            if (key_s) begin
               state_d = PRESS_CHK;
               cnt_d   = '0;
            end
         end
         PRESS_CHK: begin
            if (!key_s) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
               state_d     = PRESSED;
               cnt_d       = '0;
               press_evt_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESSED: begin
            if (!key_s) begin
               state_d = RELEASE_CHK;
               cnt_d   = '0;
            end
         end
         RELEASE_CHK: begin
            if (key_s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   // Auto-scan divider, parked at zero while disabled
   always_comb begin
      tick_cnt_d = '0;
      tick_c     = 1'b0;
      if (en_s) begin
         if (tick_cnt_q == CW'(SCAN_DIV - 1)) begin
            tick_c = 1'b1;
         end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
         end
      end
   end

`ifdef AUTOREPEAT_EN
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic          rep_phase_q, rep_phase_d;

   // Hold timer: first period is REPEAT_DELAY, later ones REPEAT_RATE
   always_comb begin
      hold_cnt_d   = '0;
      rep_phase_d  = 1'b0;
      repeat_evt_c = 1'b0;
      if (state_q == PRESSED || state_q == RELEASE_CHK) begin
         hold_cnt_d  = hold_cnt_q + CW'(1);
         rep_phase_d = rep_phase_q;
         if (hold_cnt_q == (rep_phase_q ? CW'(REPEAT_RATE - 1) : CW'(REPEAT_DELAY - 1))) begin
            repeat_evt_c = 1'b1;
            hold_cnt_d   = '0;
            rep_phase_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q  <= '0;
         rep_phase_q <= 1'b0;
      end else begin
         hold_cnt_q  <= hold_cnt_d;
         rep_phase_q <= rep_phase_d;
      end
   end
`else
   assign repeat_evt_c = 1'b0;
`endif

   // Merge advance sources; LEDR decodes the next SEL so both update together
   always_comb begin
      adv_c  = press_evt_c | tick_c | repeat_evt_c;
      sel_d  = sel_q;
      step_d = adv_c;
      if (adv_c) begin
         sel_d = dir_s ? (sel_q - 2'd1) : (sel_q + 2'd1);
      end
      led_d = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         led_d[i] = (sel_d == 2'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RELEASED;
         cnt_q      <= '0;
         tick_cnt_q <= '0;
         key_sync_q <= '0;
         en_sync_q  <= '0;
         dir_sync_q <= '0;
         sel_q      <= '0;
         led_q      <= 4'b1000;
         step_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tick_cnt_q <= tick_cnt_d;
         key_sync_q <= key_sync_d;
         en_sync_q  <= en_sync_d;
         dir_sync_q <= dir_sync_d;
         sel_q      <= sel_d;
         led_q      <= led_d;
         step_q     <= step_d;
      end
   end

   assign SEL  = sel_q;
   assign LEDR = led_q;
   assign STEP = step_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: directed scenarios plus random key/switch traffic
// checked against a run-length model of the debounce, scan and repeat rules.
module tb_mux_sel_sequencer;
   localparam int D  = 4;
   localparam int S  = 8;
   localparam int RD = 16;
   localparam int RR = 4;

   logic       clk;
   logic       rst_n, key_btn, sw_en, sw_dir;
   logic [0:1] key, sw, sel;
   logic [0:3] ledr;
   logic       step;

   assign key = {rst_n, key_btn};
   assign sw  = {sw_en, sw_dir};

   mux_sel_sequencer #(
      .DEBOUNCE_CYCLES(D),
      .SCAN_DIV       (S),
      .REPEAT_DELAY   (RD),
      .REPEAT_RATE    (RR)
   ) dut (
      .CLOCK_50(clk),
      .KEY     (key),
      .SW      (sw),
      .SEL     (sel),
      .LEDR    (ledr),
      .STEP    (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int step_log[$];

   // Reference model: inputs reach the logic two edges late; a key level is
   // accepted on its (D+1)th consecutive synchronized sample (latency 2+D+1).
   bit kq[$], eq[$], dq[$];
   bit m_acc;
   int m_run, m_en_run, m_hold, m_sel;
   bit m_step;

   function automatic void model_reset();
      kq.delete(); eq.delete(); dq.delete();
      for (int i = 0; i < 2; i++) begin
         kq.push_back(1'b0); eq.push_back(1'b0); dq.push_back(1'b0);
      end
      m_acc = 1'b0; m_run = 0; m_en_run = 0; m_hold = 0; m_sel = 0; m_step = 1'b0;
   endfunction

   function automatic void model_edge();
      bit ks, es, ds, press, tick, rep;
      ks = kq.pop_front(); kq.push_back(~key_btn);
      es = eq.pop_front(); eq.push_back(sw_en);
      ds = dq.pop_front(); dq.push_back(sw_dir);
      press = 1'b0; tick = 1'b0; rep = 1'b0;
`ifdef AUTOREPEAT_EN
      if (m_acc) begin
         m_hold++;
         if (m_hold >= RD && ((m_hold - RD) % RR) == 0) rep = 1'b1;
      end
`endif
      if (ks != m_acc) m_run++; else m_run = 0;
      if (m_run == D + 1) begin
         m_acc = ~m_acc;
         m_run = 0;
         if (m_acc) begin
            press  = 1'b1;
            m_hold = 0;
         end
      end
      if (es) begin
         m_en_run++;
         tick = ((m_en_run % S) == 0);
      end else begin
         m_en_run = 0;
      end
      m_step = press | tick | rep;
      if (m_step) m_sel = ds ? (m_sel + 3) % 4 : (m_sel + 1) % 4;
   endfunction

   function automatic logic [0:3] exp_led(input int s);
      logic [0:3] v;
      v = 4'b1000;
      return v >> s;
   endfunction

   task automatic cycle();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_edge();
      cyc++;
      #1;
      if (step === 1'b1) step_log.push_back(cyc);
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic press(input int hold, input int rel);
      key_btn = 1'b0;
      run_cycles(hold);
      key_btn = 1'b1;
      run_cycles(rel);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; key_btn = 1'b1; sw_en = 1'b0; sw_dir = 1'b0;
      run_cycles(2);
      rst_n = 1'b1;
      step_log.delete();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (sel !== 2'd0 || ledr !== 4'b1000 || step !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_init: sel=%0d ledr=%b step=%b expected 0 1000 0", sel, ledr, step);
      end
      press(10, 10);
      press(10, 10);
      n_checks++;
      if (sel !== 2'd2) begin
         n_errors++;
         $display("FAIL reset_setup_sel: got %0d expected 2", sel);
      end
      key_btn = 1'b0;
      run_cycles(4);
      #4;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (sel !== 2'd0 || ledr !== 4'b1000 || step !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_async: sel=%0d ledr=%b step=%b expected 0 1000 0", sel, ledr, step);
      end
      key_btn = 1'b1;
      run_cycles(2);
      rst_n = 1'b1;
      step_log.delete();
      run_cycles(20);
      n_checks++;
      if (step_log.size() != 0 || sel !== 2'd0) begin
         n_errors++;
         $display("FAIL reset_quiet: steps=%0d sel=%0d expected 0 0", step_log.size(), sel);
      end
   endtask

   task automatic test_clean_press();
      int t0;
      do_reset();
      t0 = cyc;
      key_btn = 1'b0;
      run_cycles(20);
      n_checks++;
      if (step_log.size() != 1) begin
         n_errors++;
         $display("FAIL press_count: got %0d steps expected 1", step_log.size());
      end else begin
         n_checks++;
         if (step_log[0] - t0 < 6 || step_log[0] - t0 > 8) begin
            n_errors++;
            $display("FAIL press_latency: got %0d cycles expected 7+-1", step_log[0] - t0);
         end
      end
      n_checks++;
      if (sel !== 2'd1 || ledr !== 4'b0100) begin
         n_errors++;
         $display("FAIL press_sel: sel=%0d ledr=%b expected 1 0100", sel, ledr);
      end
      key_btn = 1'b1;
      run_cycles(10);
      n_checks++;
      if (step_log.size() != 1 || sel !== 2'(m_sel)) begin
         n_errors++;
         $display("FAIL press_release: steps=%0d sel=%0d expected 1 %0d", step_log.size(), sel, m_sel);
      end
   endtask

   task automatic test_bounce();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         key_btn = ~key_btn;
         run_cycles(2);
      end
      key_btn = 1'b1;
      run_cycles(10);
      n_checks++;
      if (step_log.size() != 0 || sel !== 2'd0) begin
         n_errors++;
         $display("FAIL bounce_press: steps=%0d sel=%0d expected 0 0", step_log.size(), sel);
      end
      key_btn = 1'b0;
      run_cycles(10);
      for (int i = 0; i < 6; i++) begin
         key_btn = ~key_btn;
         run_cycles(2);
      end
      key_btn = 1'b1;
      run_cycles(10);
      n_checks++;
      if (step_log.size() != 1 || sel !== 2'd1 || sel !== 2'(m_sel)) begin
         n_errors++;
         $display("FAIL bounce_release: steps=%0d sel=%0d expected 1 1", step_log.size(), sel);
      end
   endtask

   task automatic test_wrap_direction();
      int ups[4] = '{1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         press(10, 10);
         n_checks++;
         if (sel !== 2'(ups[i]) || ledr !== exp_led(ups[i])) begin
            n_errors++;
            $display("FAIL wrap_up_%0d: sel=%0d ledr=%b expected %0d %b", i, sel, ledr, ups[i], exp_led(ups[i]));
         end
      end
      sw_dir = 1'b1;
      run_cycles(4);
      n_checks++;
      if (sel !== 2'd0) begin
         n_errors++;
         $display("FAIL dir_no_move: sel=%0d expected 0", sel);
      end
      press(10, 10);
      n_checks++;
      if (sel !== 2'd3 || ledr !== 4'b0001) begin
         n_errors++;
         $display("FAIL wrap_down: sel=%0d ledr=%b expected 3 0001", sel, ledr);
      end
   endtask

   task automatic test_autoscan();
      int t0;
      do_reset();
      t0 = cyc;
      sw_en = 1'b1;
      run_cycles(34);
      n_checks++;
      if (step_log.size() != 4) begin
         n_errors++;
         $display("FAIL scan_count: got %0d steps expected 4", step_log.size());
      end else begin
         n_checks++;
         if (step_log[0] - t0 != 2 + S) begin
            n_errors++;
            $display("FAIL scan_first: got %0d cycles expected %0d", step_log[0] - t0, 2 + S);
         end
         for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (step_log[i] - step_log[i-1] != S) begin
               n_errors++;
               $display("FAIL scan_period_%0d: got %0d expected %0d", i, step_log[i] - step_log[i-1], S);
            end
         end
      end
      n_checks++;
      if (sel !== 2'd0) begin
         n_errors++;
         $display("FAIL scan_sel: got %0d expected 0", sel);
      end
      // press accepted on the same edge as the next tick
      run_cycles(1);
      key_btn = 1'b0;
      run_cycles(11);
      n_checks++;
      if (step_log.size() != 5 || sel !== 2'd1 || sel !== 2'(m_sel)) begin
         n_errors++;
         $display("FAIL scan_coincide: steps=%0d sel=%0d expected 5 1", step_log.size(), sel);
      end
      key_btn = 1'b1;
      sw_en = 1'b0;
      run_cycles(30);
      n_checks++;
      if (step_log.size() != 5 || sel !== 2'd1) begin
         n_errors++;
         $display("FAIL scan_frozen: steps=%0d sel=%0d expected 5 1", step_log.size(), sel);
      end
   endtask

`ifdef AUTOREPEAT_EN
   task automatic test_autorepeat();
      int offs[5] = '{0, 16, 20, 24, 28};
      int e;
      do_reset();
      key_btn = 1'b0;
      run_cycles(7);
      e = cyc;
      run_cycles(22);
      key_btn = 1'b1;
      run_cycles(20);
      n_checks++;
      if (step_log.size() != 5) begin
         n_errors++;
         $display("FAIL repeat_count: got %0d steps expected 5", step_log.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (step_log[i] - e != offs[i]) begin
               n_errors++;
               $display("FAIL repeat_time_%0d: got +%0d expected +%0d", i, step_log[i] - e, offs[i]);
            end
         end
      end
      n_checks++;
      if (sel !== 2'd1 || sel !== 2'(m_sel)) begin
         n_errors++;
         $display("FAIL repeat_sel: got %0d expected 1", sel);
      end
   endtask
`endif

   task automatic test_random();
      int hold_left;
      do_reset();
      hold_left = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold_left == 0) begin
            key_btn   = ~key_btn;
            hold_left = int'($urandom_range(1, 12));
         end
         hold_left--;
         if ($urandom_range(0, 63) == 0) sw_en = ~sw_en;
         if ($urandom_range(0, 47) == 0) sw_dir = ~sw_dir;
         cycle();
         n_checks++;
         if (sel !== 2'(m_sel) || ledr !== exp_led(m_sel) || step !== m_step) begin
            n_errors++;
            if (n_errors < 20)
               $display("FAIL random_c%0d: sel=%0d ledr=%b step=%b expected %0d %b %b",
                        cyc, sel, ledr, step, m_sel, exp_led(m_sel), m_step);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; key_btn = 1'b1; sw_en = 1'b0; sw_dir = 1'b0;
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_wrap_direction();
      test_autoscan();
`ifdef AUTOREPEAT_EN
      test_autorepeat();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
